// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for Decode/Execute and later stages.
// Optional EX operand forwarding: define HAZARD_FORWARD_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_multi,
    input  logic              br_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              idex_bubble,
    output logic              exe_hold,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              busy
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

    typedef struct packed {
        logic              valid;
        logic              wb_en;
        logic [REG_AW-1:0] dest;
    } slot_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_st, data_hazard, ex_enter, issue_multi;

`ifdef HAZARD_FORWARD_EN
    // Source operands of the EX instruction and load flags are only needed
    // when forwarding is in play.
    logic              ex_load_q, ex_load_d, mem_load_q, mem_load_d;
    logic [REG_AW-1:0] ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
    logic              ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
`endif

    function automatic logic hits(input slot_t s, input logic [REG_AW-1:0] src,
                                  input logic rd);
        return s.valid && s.wb_en && rd && (src != '0) && (s.dest == src);
    endfunction

`ifdef HAZARD_FORWARD_EN
    function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] src,
                                            input logic rd, input slot_t m,
                                            input logic m_load, input slot_t w);
        if (hits(m, src, rd) && !m_load) return 2'd1;
        if (hits(w, src, rd))            return 2'd2;
        return 2'd0;
    endfunction
`endif

    assign busy_st = (state_q == BUSY);

    always_comb begin
        data_hazard = 1'b0;
        if (id_valid) begin
`ifdef HAZARD_FORWARD_EN
            data_hazard = ex_load_q && (hits(ex_q, id_src1, id_use1) ||
                                        hits(ex_q, id_src2, id_use2));
`else
            // No regfile write-through: wait until the producer has left WB.
            data_hazard = hits(ex_q,  id_src1, id_use1) || hits(ex_q,  id_src2, id_use2) ||
                          hits(mem_q, id_src1, id_use1) || hits(mem_q, id_src2, id_use2) ||
                          hits(wb_q,  id_src1, id_use1) || hits(wb_q,  id_src2, id_use2);
`endif
        end
    end

    assign ex_enter    = id_valid && !idex_bubble;
    assign issue_multi = ex_enter && id_multi && !exe_hold;

    // FSM state register (scoreboard shares the clock edge)
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ex_q    <= ex_d;
        mem_q   <= mem_d;
        wb_q    <= wb_d;
`ifdef HAZARD_FORWARD_EN
        ex_load_q  <= ex_load_d;
        mem_load_q <= mem_load_d;
        ex_src1_q  <= ex_src1_d;
        ex_src2_q  <= ex_src2_d;
        ex_use1_q  <= ex_use1_d;
        ex_use2_q  <= ex_use2_d;
`endif
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (issue_multi) begin
                state_d = BUSY;
                cnt_d   = CNT_LOAD;
            end
            BUSY: if (cnt_q == '0) state_d = IDLE;
                  else             cnt_d   = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // FSM outputs and hazard controls
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        idex_bubble = 1'b0;
        exe_hold    = 1'b0;
        flush_ifid  = 1'b0;
        fwd_a_sel   = 2'd0;
        fwd_b_sel   = 2'd0;
        busy        = 1'b0;
        if (!rst) begin
            busy = busy_st;
            if (br_taken) begin
                flush_ifid  = 1'b1;
                idex_bubble = 1'b1;
            end else if (busy_st) begin
                exe_hold = 1'b1;
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (data_hazard) begin
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                idex_bubble = 1'b1;
            end
`ifdef HAZARD_FORWARD_EN
            // While busy the operands latched in Decode/Execute are kept.
            if (!busy_st) begin
                fwd_a_sel = fwd_pick(ex_src1_q, ex_use1_q, mem_q, mem_load_q, wb_q);
                fwd_b_sel = fwd_pick(ex_src2_q, ex_use2_q, mem_q, mem_load_q, wb_q);
            end
`endif
        end
    end

    // Scoreboard advance: EX/MEM freeze on hold while WB drains to invalid.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = '0;
`ifdef HAZARD_FORWARD_EN
        ex_load_d  = ex_load_q;
        mem_load_d = mem_load_q;
        ex_src1_d  = ex_src1_q;
        ex_src2_d  = ex_src2_q;
        ex_use1_d  = ex_use1_q;
        ex_use2_d  = ex_use2_q;
`endif
        if (!exe_hold) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (ex_enter) ex_d = '{valid: 1'b1, wb_en: id_wb_en, dest: id_dest};
`ifdef HAZARD_FORWARD_EN
            mem_load_d = ex_load_q;
            {ex_load_d, ex_src1_d, ex_src2_d, ex_use1_d, ex_use2_d} = '0;
            if (ex_enter)
                {ex_load_d, ex_src1_d, ex_src2_d, ex_use1_d, ex_use2_d} =
                    {id_mem_r_en, id_src1, id_src2, id_use1, id_use2};
`endif
        end
        if (rst) begin
            ex_d  = '0;
            mem_d = '0;
            wb_d  = '0;
`ifdef HAZARD_FORWARD_EN
            {ex_load_d, mem_load_d, ex_src1_d, ex_src2_d, ex_use1_d, ex_use2_d} = '0;
`endif
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the Decode/Execute pipeline register and the stages after it.
- Keeps a shadow scoreboard of the destination register and control bits for the instructions in EX, MEM and WB.
- From that state it generates stall, bubble, hold and flush controls, plus EX-stage operand forwarding selects.
- Also owns the multi-cycle execute FSM that holds the EX stage while a long-latency operation completes.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero and never creates a hazard.
- MUL_LAT, 4, total EX cycles for an instruction flagged multicycle; legal range 2..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  Decode holds a real instruction
- id_src1  in  REG_AW  first source register
- id_src2  in  REG_AW  second source register
- id_use1  in  1  instruction reads src1
- id_use2  in  1  instruction reads src2; also set for store data
- id_dest  in  REG_AW  destination register
- id_wb_en  in  1  instruction writes back
- id_mem_r_en  in  1  instruction is a load
- id_multi  in  1  instruction is multi-cycle in EX
- br_taken  in  1  branch resolved taken in EX
- stall_if  out  1  hold PC and IF/ID
- stall_id  out  1  hold Decode outputs
- idex_bubble  out  1  load all-zero control into Decode/Execute
- exe_hold  out  1  Decode/Execute and EX/MEM keep their current contents
- flush_ifid  out  1  clear IF/ID to a NOP
- fwd_a_sel  out  2  EX operand A source: 0 = regfile/latched, 1 = MEM ALU result, 2 = WB value
- fwd_b_sel  out  2  EX operand B and store-data source, same encoding
- busy  out  1  multi-cycle FSM is in BUSY

Behaviour:
- Reset, cycle after rst is high:
  - Scoreboard for EX, MEM and WB is cleared (valid = 0).
  - FSM is in IDLE and the counter is 0.
  - All outputs are 0.
- Scoreboard:
  - Each slot holds valid, dest, wb_en and load; the EX slot also holds src1/src2/use1/use2.
  - On each clock where exe_hold = 0, the slots advance ID→EX→MEM→WB→drop.
  - The EX slot receives the ID fields, gated to invalid when idex_bubble = 1 or id_valid = 0.
  - When exe_hold = 1: the EX and MEM slots hold; WB receives invalid; the old WB slot drops.
- A match means: the slot is valid, the slot has wb_en set, slot dest == the source register, the source is used, and the source is nonzero.
- Priority each cycle, decided combinationally from the ID inputs and registered state:
  1. rst.
  2. br_taken: flush_ifid = 1 and idex_bubble = 1; stall_if = stall_id = 0 so the target is fetched.
  3. busy: exe_hold = stall_if = stall_id = 1 and idex_bubble = 0.
  4. Data hazard: stall_if = stall_id = idex_bubble = 1.
  5. Otherwise all controls are 0.
- Multi-cycle FSM, states IDLE and BUSY:
  - IDLE→BUSY on the clock where an id_multi instruction enters EX (not a bubble, no flush); the counter loads MUL_LAT-2.
  - In BUSY the counter decrements each clock.
  - At count 0 with busy high, the next clock returns to IDLE; total EX occupancy is MUL_LAT cycles.
  - With MUL_LAT = 2, BUSY lasts exactly one cycle.
- br_taken while busy cannot occur (the branch and the multi-cycle op would both be in EX). The verification assertion flags it; RTL ignores it.
- Forwarding, from registered slots and used only when HAZARD_FORWARD_EN is defined:
  - fwd_a_sel = 1 if the EX src1 matches MEM and the MEM slot is not a load.
  - Otherwise fwd_a_sel = 2 if it matches WB.
  - Otherwise fwd_a_sel = 0.
  - fwd_b_sel follows the same rule for src2.
  - MEM has priority over WB when both match.
  - A selector is 0 while busy, so operands latched in Decode/Execute are used.
- rst asserted while busy: the FSM aborts to IDLE on that clock and no hold is asserted on the following cycle.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined:
  - Data hazard = ID source matches an EX slot that is a load, i.e. a 1-cycle load-use stall.
  - A load in MEM is forwarded through the WB path on the next cycle.
- Undefined:
  - Data hazard = ID source matches the EX, MEM or WB slot (the regfile has no write-through), giving up to 3 stall cycles.
  - fwd_a_sel and fwd_b_sel are held at 0.

Test Plan:
- Reset check: rst high for 2 cycles with random inputs → every output is 0 and busy is 0; the first instruction after reset issues with no stall.
- Load-use (forwarding on): load r5, then add r6 = r5 + r1 → exactly 1 cycle of stall_if/stall_id/idex_bubble, then add in EX with fwd_a_sel = 2. Repeat with src = r0 → no stall.
- ALU-ALU back-to-back (forwarding on): add r3 → sub using r3 → no stall, fwd_a_sel = 1; one instruction later a user of r3 sees fwd_a_sel = 2. Same stimulus with forwarding off → 3 stall cycles and selectors always 0.
- Multi-cycle, MUL_LAT = 4: mul issued → busy and exe_hold high for 3 cycles, EX occupancy 4 cycles, the next instruction enters EX on cycle 5. Repeat with MUL_LAT = 2 → 1 hold cycle. Assert rst at the second hold cycle → IDLE next cycle.
- Branch flush: br_taken pulse while ID has a load-use hazard → flush_ifid = idex_bubble = 1, stall_if = 0, and the hazard stall is suppressed for that cycle.
- Simultaneous match (forwarding on): MEM and WB both write r7, EX reads r7 as src1 and src2 → fwd_a_sel = fwd_b_sel = 1.
